// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, response codes and the byte-lane mask helper
// used by the SRAM responder and future bus responders.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'b00,
    RESP_WAIT = 2'b01,
    RESP_ERR1 = 2'b10,
    RESP_ERR2 = 2'b11
  } resp_state_e;

  // Byte lanes touched by a transfer of the given size at the given offset.
  function automatic logic [3:0] size_mask(input logic [2:0] hsize, input logic [1:0] addr);
    logic [3:0] m;
    m = '0;
    case (hsize)
      HSIZE_BYTE: m = 4'b0001 << addr;
      HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: m = 4'b1111;
      default:    m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_wait_counter.sv
// Loadable down-counter with a done flag; counts to zero and holds there.
module ahb_wait_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = (count_q == '0);

endmodule

// File: rtl/ahb_sram_responder.sv
// AHB-Lite subordinate backed by a byte-addressed flop array, with
// configurable wait states, strobed writes and a two-cycle ERROR response.
module ahb_sram_responder
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_LSB_W  = $clog2(MEM_DEPTH)
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  WSTRB,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);

  resp_state_e            state_q, state_d;
  logic                   active_q, active_d;
  logic [ADDR_LSB_W-1:0]  addr_q;
  logic                   write_q;
  logic [2:0]             size_q;
  logic [3:0]             strb_q;

  logic [7:0]             mem_q [MEM_DEPTH];

  logic                   hready;
  logic                   accept;
  logic                   illegal;
  logic                   complete;
  logic                   wait_load;
  logic                   wait_done;
  logic [3:0]             wait_count;
  logic [3:0]             wr_lanes;
  logic [ADDR_LSB_W-3:0]  word_idx;
  logic                   unused_ok;

  assign unused_ok = ^{HBURST, HTRANS[0], wait_count};

  ahb_wait_counter #(
    .WIDTH (4)
  ) u_wait_counter (
    .clk_i      (HCLK),
    .rst_ni     (HRESETn),
    .load_i     (wait_load),
    .load_val_i (4'(WAIT_STATES)),
    .count_o    (wait_count),
    .done_o     (wait_done)
  );

  always_comb begin
    unique case (state_q)
      RESP_WAIT: hready = wait_done;
      RESP_ERR1: hready = 1'b0;
      default:   hready = 1'b1;
    endcase
  end

  assign accept  = HSEL & HREADYIN & HTRANS[1];
  assign illegal = (|HADDR[31:ADDR_LSB_W])
                 | (HSIZE > 3'd2)
                 | ((HSIZE == HSIZE_HALF) & HADDR[0])
                 | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00));

  // A legal data phase ends either in IDLE (zero-wait) or when WAIT drains.
  assign complete = ((state_q == RESP_IDLE) & active_q)
                  | ((state_q == RESP_WAIT) & wait_done);

  always_comb begin
    state_d   = state_q;
    active_d  = 1'b0;
    wait_load = 1'b0;
    if (hready) begin
      state_d = RESP_IDLE;
      if (accept) begin
        if (illegal) begin
          state_d = RESP_ERR1;
        end else if (WAIT_STATES != 0) begin
          state_d   = RESP_WAIT;
          wait_load = 1'b1;
        end else begin
          active_d = 1'b1;
        end
      end
    end else if (state_q == RESP_ERR1) begin
      state_d = RESP_ERR2;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= RESP_IDLE;
      active_q <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      strb_q   <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      // Completion reads the old captured fields combinationally, so an
      // overlapping accept may overwrite them on the same edge.
      if (hready && accept) begin
        addr_q  <= HADDR[ADDR_LSB_W-1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
        strb_q  <= WSTRB;
      end
    end
  end

  assign word_idx = addr_q[ADDR_LSB_W-1:2];

  always_comb begin
    wr_lanes = '0;
    if (complete && write_q) begin
      wr_lanes = strb_q & size_mask(size_q, addr_q[1:0]);
    end
  end

  always_ff @(posedge HCLK) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (wr_lanes[b]) begin
        mem_q[{word_idx, 2'(b)}] <= HWDATA[8*b +: 8];
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (complete && !write_q) begin
      HRDATA = {mem_q[{word_idx, 2'd3}], mem_q[{word_idx, 2'd2}],
                mem_q[{word_idx, 2'd1}], mem_q[{word_idx, 2'd0}]};
    end
  end

  assign HREADYOUT = hready;
  assign HRESP     = ((state_q == RESP_ERR1) || (state_q == RESP_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule
